// File: rtl/sdpb_line_packer_if.sv
// Byte-stream in / SDPB write-port out bundle for the line packer.
// master drives the pixel stream and observes the write port; slave is the packer.
interface sdpb_line_packer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
);
    logic              sol;
    logic              eol;
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              wr_cea;
    logic [ADDR_W-1:0] wr_ada;
    logic [DATA_W-1:0] wr_din;
    logic              line_done;
    logic [ADDR_W:0]   line_words;
    logic              overflow;

    modport master (
        output sol, eol, pix_valid, pix_data,
        input  wr_cea, wr_ada, wr_din, line_done, line_words, overflow
    );

    modport slave (
        input  sol, eol, pix_valid, pix_data,
        output wr_cea, wr_ada, wr_din, line_done, line_words, overflow
    );
endinterface

// File: rtl/sdpb_line_packer.sv
// Packs a byte stream into DATA_W-bit words for the SDPB line memory write port,
// bracketing each line with sol/eol, padding the last word and flagging overflow.
//
// state | meaning
// IDLE  | between lines; bytes and eol ignored, waiting for sol
// FILL  | line open; bytes collected into lanes, words written as they fill
module sdpb_line_packer #(
    parameter int         ADDR_W   = 7,
    parameter int         DATA_W   = 128,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              resetn,
    sdpb_line_packer_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              cea_q, cea_d;
    logic [ADDR_W-1:0] ada_q, ada_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic [DATA_W-1:0] word;
    logic [LW-1:0]     lane_n;
    logic [ADDR_W:0]   cnt_n;
    logic              full;
    logic              emit;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        cea_d   = 1'b0;
        ada_d   = ada_q;
        din_d   = din_q;
        done_d  = 1'b0;
        words_d = words_q;
        word    = buf_q;
        lane_n  = lane_q;
        cnt_n   = cnt_q;
        full    = 1'b0;
        emit    = 1'b0;

        if (bus.sol) begin
            // sol restarts the line from any state; a partial word is simply dropped
            state_d = FILL;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            words_d = '0;
            word    = '0;
            lane_d  = '0;
            if (bus.pix_valid) begin
                word[7:0] = bus.pix_data;
                lane_d    = LW'(1);
            end
            buf_d = word;
        end else if (state_q == FILL) begin
            if (bus.pix_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    if (LW'(k) == lane_q) word[k*8 +: 8] = bus.pix_data;
                end
                if (lane_q == LW'(LANES - 1)) begin
                    full   = 1'b1;
                    lane_n = '0;
                end else begin
                    lane_n = lane_q + LW'(1);
                end
            end
            if (full) begin
                emit = 1'b1;
            end else if (bus.eol && lane_n != '0) begin
                for (int k = 0; k < LANES; k++) begin
                    if (LW'(k) >= lane_n) word[k*8 +: 8] = PAD_BYTE;
                end
                emit = 1'b1;
            end
            if (emit) begin
                if (cnt_q < (ADDR_W + 1)'(DEPTH)) begin
                    cea_d = 1'b1;
                    ada_d = cnt_q[ADDR_W-1:0];
                    din_d = word;
                    cnt_n = cnt_q + (ADDR_W + 1)'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            lane_d = lane_n;
            cnt_d  = cnt_n;
            buf_d  = emit ? '0 : word;
            if (bus.eol) begin
                done_d  = 1'b1;
                words_d = cnt_n;
                state_d = IDLE;
                lane_d  = '0;
                buf_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            lane_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            cea_q   <= 1'b0;
            ada_q   <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            cea_q   <= cea_d;
            ada_q   <= ada_d;
            din_q   <= din_d;
            done_q  <= done_d;
            words_q <= words_d;
        end
    end

    assign bus.wr_cea     = cea_q;
    assign bus.wr_ada     = ada_q;
    assign bus.wr_din     = din_q;
    assign bus.line_done  = done_q;
    assign bus.line_words = words_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_sdpb_line_packer.sv
// Self-checking bench for sdpb_line_packer: table of line shapes, a word scoreboard,
// and hand-written sequences for sol restart and mid-line reset.
module tb_sdpb_line_packer;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 128;

    typedef struct packed {
        logic [ADDR_W-1:0] ada;
        logic [DATA_W-1:0] din;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] base;
        bit         eol_last;
        int         exp_words;
        bit         exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sdpb_line_packer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdpb_line_packer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAD_BYTE(8'h00)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int  checks = 0;
    int  errors = 0;
    wr_t sb[$];
    bit  done_exp = 1'b0;
    int  words_exp = 0;
    bit  ovf_exp = 1'b0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.wr_cea === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: ada %0h din %0h with nothing expected", bus.wr_ada, bus.wr_din);
            end else begin
                e = sb.pop_front();
                chk("wr_ada", DATA_W'(bus.wr_ada), DATA_W'(e.ada));
                chk("wr_din", bus.wr_din, e.din);
            end
        end
        chk("line_done", DATA_W'(bus.line_done), DATA_W'(done_exp));
        if (done_exp) begin
            chk("line_words", DATA_W'(bus.line_words), DATA_W'(words_exp));
            chk("overflow", DATA_W'(bus.overflow), DATA_W'(ovf_exp));
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w, inout int nw);
        wr_t e;
        if (nw < DEPTH) begin
            e.ada = ADDR_W'(nw);
            e.din = w;
            sb.push_back(e);
        end
        nw++;
    endtask

    // Drives one line; expected words are pushed as the bytes that complete them are driven.
    task automatic run_line(input int n, input logic [7:0] base, input bit eol_last,
                            input bit sol_byte, input int exp_words, input bit exp_ovf);
        logic [DATA_W-1:0] cur;
        int lane;
        int nw;
        cur = '0; lane = 0; nw = 0;
        bus.eol = 1'b0;
        bus.pix_valid = 1'b0;
        if (!sol_byte) begin
            bus.sol = 1'b1;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            bus.sol = (sol_byte && i == 0);
            bus.pix_valid = 1'b1;
            bus.pix_data = base + 8'(i);
            bus.eol = (eol_last && i == n - 1);
            cur[lane*8 +: 8] = bus.pix_data;
            lane++;
            if (lane == DATA_W / 8) begin
                push_word(cur, nw);
                cur = '0;
                lane = 0;
            end else if (bus.eol) begin
                push_word(cur, nw);
            end
            tick();
        end
        if (!eol_last || n == 0) begin
            bus.sol = 1'b0;
            bus.pix_valid = 1'b0;
            bus.eol = 1'b1;
            if (lane > 0) push_word(cur, nw);
            tick();
        end
        done_exp = 1'b1;
        words_exp = exp_words;
        ovf_exp = exp_ovf;
        bus.sol = 1'b0;
        bus.eol = 1'b0;
        bus.pix_valid = 1'b0;
        tick();
        done_exp = 1'b0;
        chk("sb_drained", DATA_W'(sb.size()), '0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32,   8'h00, 1'b0, 2,   1'b0};
        vecs[1] = '{20,   8'h00, 1'b0, 2,   1'b0};
        vecs[2] = '{16,   8'h40, 1'b1, 1,   1'b0};
        vecs[3] = '{17,   8'h55, 1'b1, 2,   1'b0};
        vecs[4] = '{1,    8'h77, 1'b0, 1,   1'b0};
        vecs[5] = '{0,    8'h00, 1'b0, 0,   1'b0};
        vecs[6] = '{2064, 8'h00, 1'b0, 128, 1'b1};
        vecs[7] = '{2048, 8'h10, 1'b0, 128, 1'b0};
        vecs[8] = '{2049, 8'h20, 1'b1, 128, 1'b1};

        resetn = 1'b0;
        bus.sol = 1'b0;
        bus.eol = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data = 8'h00;
        tick();
        tick();
        @(negedge clk);
        chk("rst_cea", DATA_W'(bus.wr_cea), '0);
        chk("rst_ada", DATA_W'(bus.wr_ada), '0);
        chk("rst_din", bus.wr_din, '0);
        chk("rst_words", DATA_W'(bus.line_words), '0);
        chk("rst_ovf", DATA_W'(bus.overflow), '0);
        resetn = 1'b1;

        // bytes and eol while IDLE must do nothing
        bus.pix_valid = 1'b1;
        bus.pix_data = 8'hAA;
        repeat (20) tick();
        bus.eol = 1'b1;
        tick();
        bus.eol = 1'b0;
        bus.pix_valid = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_line(vecs[v].n, vecs[v].base, vecs[v].eol_last, 1'b0,
                     vecs[v].exp_words, vecs[v].exp_ovf);
            @(negedge clk);
            chk("ovf_hold", DATA_W'(bus.overflow), DATA_W'(vecs[v].exp_ovf));
        end

        // sol clears the sticky overflow left by the last line
        bus.sol = 1'b1;
        tick();
        bus.sol = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", DATA_W'(bus.overflow), '0);

        // sol mid-line with a byte: old partial word discarded, byte lands in lane 0
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data = 8'hE0 + 8'(i);
            tick();
        end
        run_line(18, 8'hA0, 1'b0, 1'b1, 2, 1'b0);

        // mid-line reset aborts the line
        bus.sol = 1'b1;
        tick();
        bus.sol = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data = 8'h30 + 8'(i);
            tick();
        end
        bus.pix_valid = 1'b0;
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_cea", DATA_W'(bus.wr_cea), '0);
        chk("mid_rst_ada", DATA_W'(bus.wr_ada), '0);
        chk("mid_rst_din", bus.wr_din, '0);
        chk("mid_rst_words", DATA_W'(bus.line_words), '0);
        chk("mid_rst_ovf", DATA_W'(bus.overflow), '0);
        resetn = 1'b1;
        bus.eol = 1'b1;
        tick();
        bus.eol = 1'b0;
        bus.pix_valid = 1'b1;
        repeat (20) tick();
        bus.pix_valid = 1'b0;
        repeat (3) tick();
        chk("final_sb_empty", DATA_W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
